// File: rtl/mul_seq_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mul_seq_ctrl : iterative shift-add multiplier sequencer owning hi/lo
// Revision 1.0
// ---------------------------------------------------------------------------
module mul_seq_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_op,
  input  logic             abort,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int                   CW    = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]        LAST  = CW'(WIDTH - 1);
  localparam logic [CW-1:0]        CNT1  = CW'(1);
  localparam logic [WIDTH-1:0]     ONE_W = WIDTH'(1);
  localparam logic [2*WIDTH-1:0]   ONE_P = (2*WIDTH)'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t               state, state_nx;
  logic [WIDTH-1:0]     mag_a;
  logic [WIDTH-1:0]     mq;
  logic [WIDTH:0]       acc;
  logic [CW-1:0]        count;
  logic                 neg;
  logic                 accept;
  logic [WIDTH:0]       sum;
  logic [2*WIDTH-1:0]   prod;
  logic [2*WIDTH-1:0]   prod_fix;

  assign accept = (state == IDLE) & start & ~abort;

  // acc bit WIDTH is always zero after the shift, so only the low half is added
  always_comb begin
    sum = acc;
    if (mq[0]) sum = {1'b0, acc[WIDTH-1:0]} + {1'b0, mag_a};
  end

  assign prod     = {acc[WIDTH-1:0], mq};
  assign prod_fix = neg ? (~prod + ONE_P) : prod;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = (state != IDLE);
    stall    = (state == RUN) | (state == FIX) | accept;
    case (state)
      IDLE:    if (accept) state_nx = RUN;
      RUN:     if (abort) state_nx = IDLE;
               else if (count == LAST) state_nx = FIX;
      FIX:     state_nx = abort ? IDLE : DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mag_a <= '0;
      mq    <= '0;
      acc   <= '0;
      count <= '0;
      neg   <= 1'b0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      done <= (state == FIX) & ~abort;
      case (state)
        IDLE: if (accept) begin
          // the negated most-negative value is itself, which reads correctly as unsigned
          mag_a <= (signed_op & opa[WIDTH-1]) ? (~opa + ONE_W) : opa;
          mq    <= (signed_op & opb[WIDTH-1]) ? (~opb + ONE_W) : opb;
          neg   <= signed_op & (opa[WIDTH-1] ^ opb[WIDTH-1]);
          acc   <= '0;
          count <= '0;
        end
        RUN: begin
          acc   <= {1'b0, sum[WIDTH:1]};
          mq    <= {sum[0], mq[WIDTH-1:1]};
          count <= count + CNT1;
        end
        FIX: if (!abort) {hi, lo} <= prod_fix;
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mul_seq_ctrl.sv
`default_nettype none
// Directed self-checking bench for mul_seq_ctrl (WIDTH = 32).
module tb_mul_seq_ctrl;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, start, signed_op, abort;
  logic [W-1:0] opa, opb;
  logic         busy, stall, done;
  logic [W-1:0] hi, lo;

  int tests = 0;
  int fails = 0;

  mul_seq_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .signed_op(signed_op),
    .abort(abort), .opa(opa), .opb(opb), .busy(busy), .stall(stall),
    .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one op starting in the current cycle and checks every cycle up to done.
  // Returns in cycle W+3 relative to the start.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input logic [63:0] exp, input bit hold);
    opa = a; opb = b; signed_op = s; start = 1'b1;
    for (int c = 0; c <= W + 2; c++) begin
      if (c > 0 && !hold) start = 1'b0;
      #1;
      check({tag, ".stall"}, 64'(stall), 64'(c <= W + 1));
      check({tag, ".done"},  64'(done),  64'(c == W + 2));
      check({tag, ".busy"},  64'(busy),  64'(c != 0));
      if (c == W + 2) check({tag, ".prod"}, {hi, lo}, exp);
      tick();
    end
    #1;
    check({tag, ".idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ndone;
    reset = 1'b1; start = 1'b0; signed_op = 1'b0; abort = 1'b0; opa = '0; opb = '0;
    tick(); tick();
    reset = 1'b0;
    #1;
    check("rst.busy",  64'(busy),  64'd0);
    check("rst.stall", 64'(stall), 64'd0);
    check("rst.done",  64'(done),  64'd0);
    check("rst.hilo",  {hi, lo},   64'd0);
    tick();

    run_op("u3x5",   32'd3,          32'd5,          1'b0, 64'h00000000_0000000F, 1'b0);
    run_op("uff",    32'hFFFFFFFF,   32'hFFFFFFFF,   1'b0, 64'hFFFFFFFE_00000001, 1'b0);
    run_op("s-7x3",  32'hFFFFFFF9,   32'h00000003,   1'b1, 64'hFFFFFFFF_FFFFFFEB, 1'b0);
    run_op("smin2",  32'h80000000,   32'h80000000,   1'b1, 64'h40000000_00000000, 1'b0);
    run_op("sminx1", 32'h80000000,   32'h00000001,   1'b1, 64'hFFFFFFFF_80000000, 1'b0);

    // abort with an ignored mid-run start
    run_op("u6x7",   32'd6,          32'd7,          1'b0, 64'h00000000_0000002A, 1'b0);
    opa = 32'd9; opb = 32'd9; signed_op = 1'b0; start = 1'b1;
    for (int c = 0; c <= 10; c++) begin
      if (c == 1) start = 1'b0;
      if (c == 5) start = 1'b1;
      if (c == 6) start = 1'b0;
      if (c == 10) abort = 1'b1;
      #1;
      check("abt.done", 64'(done), 64'd0);
      if (c > 0) check("abt.busy", 64'(busy), 64'd1);
      tick();
    end
    abort = 1'b0;
    #1;
    check("abt.idle", 64'(busy), 64'd0);
    check("abt.hilo", {hi, lo},  64'h00000000_0000002A);
    run_op("u9x9",   32'd9,          32'd9,          1'b0, 64'h00000000_00000051, 1'b0);

    // reset mid-run after a completed product
    opa = 32'd12; opb = 32'd11; start = 1'b1;
    for (int c = 0; c <= 15; c++) begin
      if (c == 1) start = 1'b0;
      if (c == 15) reset = 1'b1;
      #1;
      tick();
    end
    reset = 1'b0;
    #1;
    check("mrst.busy",  64'(busy),  64'd0);
    check("mrst.stall", 64'(stall), 64'd0);
    check("mrst.done",  64'(done),  64'd0);
    check("mrst.hilo",  {hi, lo},   64'd0);
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (done) ndone++;
    end
    check("mrst.nodone", 64'(ndone), 64'd0);

    // back-to-back with start held high
    run_op("b2b.1", 32'd2, 32'd2, 1'b0, 64'd4, 1'b1);
    run_op("b2b.2", 32'd2, 32'd2, 1'b0, 64'd4, 1'b1);
    start = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mul_seq_ctrl.md
# mul_seq_ctrl

Multi-cycle sequencer for the MIPS `mul` operation, which the ALU control decodes as alucontrol 4'b0110. It accepts two operands from the execute stage on a start pulse and runs an iterative shift-add over WIDTH cycles, applying a sign fix-up afterwards. It stalls the pipeline while running and returns a 2×WIDTH product on hi/lo with a one-cycle done pulse. It sits beside the ALU in the execute stage and owns the hi/lo result registers.

## Interface
- WIDTH, 32, operand width in bits; must be ≥ 2.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high; clears all state and outputs.
- start  in  1  request a multiply; sampled only in IDLE.
- signed_op  in  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
- abort  in  1  synchronous cancel of an in-flight op (pipeline flush).
- opa  in  WIDTH  multiplicand; sampled with start.
- opb  in  WIDTH  multiplier; sampled with start.
- busy  out  1  high whenever state ≠ IDLE.
- stall  out  1  combinational: (state ∈ {RUN, FIX}) | (state = IDLE & start & ~abort).
- done  out  1  registered; one-cycle pulse when hi/lo hold a new product.
- hi  out  WIDTH  upper product half, registered.
- lo  out  WIDTH  lower product half, registered.

## Operation
- States: IDLE, RUN, FIX, DONE. Reset → IDLE; busy=0, done=0, hi=0, lo=0, and all internal registers 0.
- IDLE → RUN when start=1 and abort=0.
  - Latch mag_a = |opa| and mag_b = |opb| when signed_op=1, else the raw values.
  - Latch neg = signed_op & (opa[W-1] ^ opb[W-1]).
  - Clear acc (WIDTH+1 bits, including carry) and count.
- RUN, one iteration per cycle:
  - If mq[0]=1, acc = acc_hi + mag_a, computed WIDTH+1 wide.
  - Then shift {acc, mq} right by one. mq is initialised from mag_b.
  - count increments. After iteration WIDTH-1 completes (count reaches WIDTH), go to FIX.
- FIX: the product P is the 2W-bit {acc_hi, mq}. If neg, P = ~P + 1, computed 2W wide with the carry discarded. Go to DONE.
- DONE: hi/lo were loaded from P on the FIX→DONE edge, and done=1 for this cycle only. Go to IDLE.
- Magnitude of the most-negative value, −2^(W-1), is 2^(W-1) and fits unsigned W bits; no special case is needed.
- hi/lo change only on the FIX→DONE edge or on reset. They hold their value through IDLE, RUN, abort, and ignored starts.
- start outside IDLE is ignored; nothing is queued.
- abort in RUN, FIX, or DONE: next state is IDLE, done stays 0, and hi/lo are unchanged.
  - abort in the DONE cycle does not retract done, because the result is already committed.
  - abort with start in IDLE: abort wins and start is ignored.
- reset has priority over every other input in every state.

## Timing
- Cycle 0 is the IDLE cycle where start=1 is sampled. stall=1 in cycle 0.
- Cycles 1..WIDTH: RUN, with stall=1 and busy=1.
- Cycle WIDTH+1: FIX, with stall=1.
- Cycle WIDTH+2: DONE, with done=1, hi/lo valid, stall=0, and busy=1. The pipeline advances and captures hi/lo in this cycle.
- Cycle WIDTH+3: IDLE, with busy=0. The earliest next accepted start is this cycle.
- Latency from start to done is WIDTH+2 cycles (34 for WIDTH=32). Throughput is one op per WIDTH+3 cycles.
- Abort sampled in cycle n gives IDLE with busy=0 in cycle n+1. A start in cycle n+1 is accepted.
- Reset asserted in any cycle: the next cycle has state IDLE and all outputs 0.

## Test plan
- Unsigned 3 × 5, start at cycle 0 → done=1 only in cycle 34; hi=0x00000000, lo=0x0000000F; stall=1 in cycles 0–33 and 0 in cycle 34.
- Unsigned 0xFFFFFFFF × 0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001. This exercises the carry into acc bit WIDTH.
- Signed cases:
  - −7 × 3 (0xFFFFFFF9 × 0x00000003) → hi=0xFFFFFFFF, lo=0xFFFFFFEB.
  - 0x80000000 × 0x80000000 → hi=0x40000000, lo=0x00000000.
  - 0x80000000 × 0x00000001 → hi=0xFFFFFFFF, lo=0x80000000.
- Abort and ignored start:
  - Complete 6 × 7 (lo=0x2A).
  - Start 9 × 9, pulse start again in cycle 5, and assert abort in cycle 10.
  - Required: no done pulse; busy=0 in cycle 11; hi/lo still 0/0x2A.
  - A new start in cycle 11 is accepted and yields done in cycle 45.
- Reset mid-RUN at cycle 15 of an op that follows a completed product → cycle 16 has busy=0, stall=0, done=0, hi=0, lo=0. There is no spurious done within the next 40 cycles.
- Back-to-back: start 2 × 2 in cycle 0 and hold start=1 → done in cycle 34 with lo=4, second op accepted in cycle 35, second done in cycle 69.
